// File: rtl/rca80_b16_pkg.sv
// Shared constants and operand type for the 80-bit blocked ripple-carry adder.
package rca80_b16_pkg;

  localparam int ADD_WIDTH = 80;
  localparam int ADD_BLK   = 16;

  typedef logic [ADD_WIDTH-1:0] operand_t;

endpackage

// File: rtl/rca80_b16_blk16.sv
// One BLK-bit ripple-carry block: a plain chain of full-adder bit cells.
module rca_blk16
  import rca80_b16_pkg::*;
#(
  parameter int BLK = ADD_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < BLK; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign s[i]     = p ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & p);
  end

  assign co = c[BLK];

endmodule

// File: rtl/rca80_b16.sv
// 80-bit adder as cascaded ripple-carry blocks with a registered sum and carry-out.
module rca80_b16
  import rca80_b16_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int BLK   = ADD_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int NBLK = WIDTH / BLK;

  logic [NBLK:0]    c;
  logic [WIDTH-1:0] s_next;

  assign c[0] = Cin;

  // Block carry-outs feed the next block directly; no lookahead across boundaries.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    rca_blk16 #(
      .BLK(BLK)
    ) u_blk (
      .a (A[k*BLK +: BLK]),
      .b (B[k*BLK +: BLK]),
      .ci(c[k]),
      .s (s_next[k*BLK +: BLK]),
      .co(c[k + 1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= s_next;
      Cout <= c[NBLK];
    end
  end

endmodule

// File: tb/tb_rca80_b16.sv
// Directed and random checks of rca80_b16 through a one-cycle-latency scoreboard.
module tb_rca80_b16;
  import rca80_b16_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  operand_t A, B;
  logic     Cin;
  operand_t S;
  logic     Cout;

  logic [ADD_WIDTH:0] exp_q[$];
  string              tag_q[$];
  int                 n_assert = 0;
  int                 n_fail   = 0;

  operand_t           ra, rb;
  logic               rc;
  logic [95:0]        rnd;

  localparam operand_t ONES = {ADD_WIDTH{1'b1}};
  localparam operand_t ZERO = '0;

  rca80_b16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  function automatic logic [ADD_WIDTH:0] ref_sum(input operand_t a, input operand_t b,
                                                 input logic ci);
    return {1'b0, a} + {1'b0, b} + {{ADD_WIDTH{1'b0}}, ci};
  endfunction

  task automatic check_out();
    logic [ADD_WIDTH:0] exp;
    string              tag;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h required=entry", {Cout, S});
      return;
    end
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    n_assert++;
    assert ({Cout, S} === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed Cout=%b S=%h required Cout=%b S=%h",
             tag, Cout, S, exp[ADD_WIDTH], exp[ADD_WIDTH-1:0]);
    end
  endtask

  // Drive one vector, record its expected registered result, check after the edge.
  task automatic apply(input operand_t a, input operand_t b, input logic ci,
                       input logic r, input logic [ADD_WIDTH:0] exp, input string tag);
    A     = a;
    B     = b;
    Cin   = ci;
    rst_n = r;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    A     = 80'h123456789ABCDEF01234;
    B     = 80'hFEDCBA9876543210FEDC;
    Cin   = 1'b1;
    rst_n = 1'b0;

    apply(80'h123456789ABCDEF01234, 80'hFEDCBA9876543210FEDC, 1'b1, 1'b0, '0, "reset_edge1");
    apply(ONES, ONES, 1'b1, 1'b0, '0, "reset_edge2");

    apply(80'h1, 80'h1, 1'b0, 1'b1, {1'b0, 80'h00000000000000000002}, "first_after_reset");
    apply(80'h00000000FFFFFFFFFFFF, 80'h1, 1'b0, 1'b1,
          {1'b0, 80'h00000001000000000000}, "cross_block_ripple");
    apply(ZERO, ZERO, 1'b1, 1'b1, {1'b0, 80'h00000000000000000001}, "carry_in_only");
    apply(80'hABCDEF1234567890FFFF, 80'h11111111111111111111, 1'b1, 1'b1,
          {1'b0, 80'hBCDF0023456789A21111}, "mixed_large");
    apply(ONES, ZERO, 1'b1, 1'b1, {1'b1, ZERO}, "full_overflow");
    apply(ONES, ONES, 1'b1, 1'b1, {1'b1, ONES}, "ones_plus_ones_cin");
    apply(ONES, ONES, 1'b0, 1'b1, {1'b1, ONES - 80'h1}, "ones_plus_ones");
    apply(ZERO, ZERO, 1'b0, 1'b1, {1'b0, ZERO}, "zero_sum");
    apply(80'h0000FFFFFFFFFFFFFFFF, ZERO, 1'b1, 1'b1,
          {1'b0, 80'h00010000000000000000}, "carry_into_block4");

    // Back-to-back vectors with a single reset edge in the middle.
    apply(80'h00000000000000000005, 80'h00000000000000000007, 1'b0, 1'b1,
          {1'b0, 80'h0000000000000000000C}, "b2b_0");
    apply(80'h8000000000000000000F, 80'h80000000000000000001, 1'b0, 1'b1,
          {1'b1, 80'h00000000000000000010}, "b2b_1");
    apply(80'h0000000000000000FFFF, 80'h0000000000000000FFFF, 1'b1, 1'b0, '0, "midstream_reset");
    apply(80'h0000000000000000FFFF, 80'h0000000000000000FFFF, 1'b1, 1'b1,
          {1'b0, 80'h0000000000000001FFFF}, "resume_after_reset");
    apply(80'h7FFFFFFFFFFFFFFFFFFF, 80'h1, 1'b0, 1'b1,
          {1'b0, 80'h80000000000000000000}, "b2b_2");

    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      ra  = rnd[ADD_WIDTH-1:0];
      rnd = {$urandom, $urandom, $urandom};
      rb  = rnd[ADD_WIDTH-1:0];
      rc  = 1'($urandom_range(0, 1));
      if ((i % 16) == 3) ra = ONES;
      if ((i % 16) == 7) rb = ~ra;
      apply(ra, rb, rc, 1'b1, ref_sum(ra, rb, rc), "random");
    end

    n_assert++;
    assert (exp_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d required=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rca80_b16.md
Name: rca80_b16

Overview:
- 80-bit ripple-carry adder built as five cascaded 16-bit ripple-carry blocks. Each block is a chain of full adders.
- The sum and carry-out are registered on one clock.
- It is a datapath arithmetic primitive. Wider ALUs and bignum units instantiate it wherever a simple, area-cheap, long-carry adder is acceptable.

Parameters:
- WIDTH, 80, total operand/sum width; must be a positive multiple of BLK.
- BLK, 16, width of each ripple-carry block; number of blocks = WIDTH/BLK (5 by default).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry into bit 0.
- S  output  WIDTH  registered sum A+B+Cin, modulo 2^WIDTH.
- Cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Clocking: one clock domain, clk. Reset is synchronous and active-low: rst_n sampled low on a rising clk edge clears state.
- Reset values: S = 0, Cout = 0. Reset has priority over the load of a new sum.
- Datapath (combinational):
  - Block k (k = 0..WIDTH/BLK-1) adds A[k*BLK +: BLK] + B[k*BLK +: BLK] + c_k.
  - c_0 = Cin; c_(k+1) = carry out of block k.
  - Inside each block, carry ripples bit by bit through full adders: s = a^b^c, co = a&b | c&(a^b).
  - No carry-lookahead or carry-select anywhere.
- Result: {Cout_next, S_next} = A + B + Cin, computed as a WIDTH+1-bit unsigned sum. Cout_next is its MSB.
- Latency: exactly 1 cycle. Inputs present before rising edge n appear on S/Cout after edge n, held until the next edge.
- Throughput: one addition per cycle. No handshake and no valid signals. Outputs update every non-reset edge.
- Inputs are not registered. A/B/Cin must be stable for a full-length ripple path before the edge.
- Boundary conditions:
  - Overflow wraps modulo 2^WIDTH with Cout = 1. Example: all-ones + 0 + Cin=1 gives S = 0, Cout = 1.
  - A carry generated in block 0 must propagate through every block boundary.
  - Cin = 1 with both operands 0 gives S = 1.
  - Reset asserted mid-stream: the next edge clears the outputs regardless of inputs. The first edge with rst_n high loads the then-current sum.
- No X propagation from reset state. Outputs are defined from the first reset edge onward.

Decomposition:
- Shared package: constants ADD_WIDTH = 80 and ADD_BLK = 16, and a typedef for the WIDTH-bit operand vector.
- One natural sub-module: rca_blk16, a parameterised BLK-bit ripple-carry block.
  - Ports: a, b, ci, s, co.
  - Internally a generate loop of full-adder bit cells.
- Top level instantiates WIDTH/BLK copies of rca_blk16 with the carry chained between them, plus the output register.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with arbitrary inputs -> S=0, Cout=0. Release, A=1, B=1, Cin=0 -> one edge later S=80'h00000000000000000002, Cout=0.
- Cross-block ripple: A=80'h00000000FFFFFFFFFFFF, B=1, Cin=0 -> S=80'h00000001000000000000, Cout=0 (carry crosses blocks 0-2 into block 3).
- Carry-in only: A=0, B=0, Cin=1 -> S=80'h00000000000000000001, Cout=0.
- Mixed large: A=80'hABCDEF1234567890FFFF, B=80'h11111111111111111111, Cin=1 -> S=80'hBCDF0023456789A21111, Cout=0.
- Full overflow: A=80'hFFFFFFFFFFFFFFFFFFFF, B=0, Cin=1 -> S=0, Cout=1. Also A=B=all-ones, Cin=1 -> S=all-ones, Cout=1.
- Back-to-back and mid-stream reset: change inputs every cycle -> each result appears exactly 1 cycle later. Assert rst_n=0 for one edge mid-stream -> outputs 0 for that cycle, then resume with the current inputs. Finish with 1000 random vectors checked against the WIDTH+1-bit reference sum.
